// File: rtl/execute.sv
// Execute stage of the five-stage MIPS pipeline: D->E register, ALU, HI/LO,
// single-cycle multiplier and a 32-step restoring divider with stall request.
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        FlushE,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        jumpD,
    input  logic [3:0]  MemtoRegD,
    input  logic [3:0]  ALUControlD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic [2:0]  MultOpD,
    input  logic [1:0]  MfSelD,
    input  logic [4:0]  ShamtD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] SignImmD,
    input  logic [31:0] PCPlus4D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        jumpE,
    output logic [3:0]  MemtoRegE,
    output logic [4:0]  WriteRegE,
    output logic [31:0] ALUMultOutE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCPlus4E,
    output logic        StallMD
);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic [3:0]  mem_to_reg;
        logic [3:0]  alu_control;
        logic        alu_src;
        logic [2:0]  mult_op;
        logic [1:0]  mf_sel;
        logic [4:0]  shamt;
        logic [4:0]  write_reg;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sign_imm;
        logic [31:0] pc_plus4;
    } e_reg_t;

    typedef enum logic {DIV_IDLE = 1'b0, DIV_RUN = 1'b1} div_state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    e_reg_t      r_e;
    e_reg_t      w_d;
    div_state_t  r_div_state;
    div_state_t  w_div_state_nxt;
    logic [31:0] r_hi, r_lo;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_quot, r_rem, r_divisor, r_dividend;
    logic        r_neg_q, r_neg_r, r_by_zero;
    logic        w_md_busy, w_div_start, w_div_last, w_stall, w_fits, w_signed_div;
    logic [31:0] w_src_b, w_alu, w_quot_next, w_rem_next, w_q_final, w_r_final;
    logic [32:0] w_rem_shift, w_rem_sub;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_md_busy   = (r_div_state == DIV_RUN);
    assign w_div_last  = w_md_busy && (r_div_cnt == 5'd31);
    assign w_div_start = (r_div_state == DIV_IDLE) &&
                         ((r_e.mult_op == MD_DIV) || (r_e.mult_op == MD_DIVU));
    assign w_signed_div = (r_e.mult_op == MD_DIV);
    assign w_stall = ((MultOpD != 3'd0) || (MfSelD != 2'd0)) &&
                     (w_md_busy || (r_e.mult_op == MD_DIV) || (r_e.mult_op == MD_DIVU));

    // Gather decode-stage fields into the E-register image
    always_comb begin
        w_d             = '0;
        w_d.reg_write   = RegWriteD;
        w_d.mem_write   = MemWriteD;
        w_d.jump        = jumpD;
        w_d.mem_to_reg  = MemtoRegD;
        w_d.alu_control = ALUControlD;
        w_d.alu_src     = ALUSrcD;
        w_d.mult_op     = MultOpD;
        w_d.mf_sel      = MfSelD;
        w_d.shamt       = ShamtD;
        w_d.write_reg   = RegDstD ? RdD : RtD;
        w_d.rd1         = RD1D;
        w_d.rd2         = RD2D;
        w_d.sign_imm    = SignImmD;
        w_d.pc_plus4    = PCPlus4D;
    end

    // D->E pipeline register; flush or HI/LO stall inserts an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e <= '0;
        end else if (FlushE || w_stall) begin
            r_e <= '0;
        end else begin
            r_e <= w_d;
        end
    end

    // ALU datapath
    always_comb begin
        w_alu   = 32'd0;
        w_src_b = r_e.alu_src ? r_e.sign_imm : r_e.rd2;
        case (r_e.alu_control)
            4'd0:    w_alu = r_e.rd1 & w_src_b;
            4'd1:    w_alu = r_e.rd1 | w_src_b;
            4'd2:    w_alu = r_e.rd1 + w_src_b;
            4'd3:    w_alu = r_e.rd1 ^ w_src_b;
            4'd4:    w_alu = ~(r_e.rd1 | w_src_b);
            4'd6:    w_alu = r_e.rd1 - w_src_b;
            4'd7:    w_alu = {31'd0, $signed(r_e.rd1) < $signed(w_src_b)};
            4'd8:    w_alu = w_src_b << r_e.shamt;
            4'd9:    w_alu = w_src_b >> r_e.shamt;
            4'd10:   w_alu = $unsigned($signed(w_src_b) >>> r_e.shamt);
            4'd11:   w_alu = {31'd0, r_e.rd1 < w_src_b};
            default: w_alu = 32'd0;
        endcase
    end

    // Result source select
    always_comb begin
        case (r_e.mf_sel)
            2'd1:    ALUMultOutE = r_hi;
            2'd2:    ALUMultOutE = r_lo;
            default: ALUMultOutE = w_alu;
        endcase
    end

    assign w_prod_s = {{32{r_e.rd1[31]}}, r_e.rd1} * {{32{r_e.rd2[31]}}, r_e.rd2};
    assign w_prod_u = {32'd0, r_e.rd1} * {32'd0, r_e.rd2};

    // One restoring step; the last step's result feeds the sign fix directly
    assign w_rem_shift = {r_rem, r_quot[31]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
    assign w_fits      = ~w_rem_sub[32];
    assign w_rem_next  = w_fits ? w_rem_sub[31:0] : w_rem_shift[31:0];
    assign w_quot_next = {r_quot[30:0], w_fits};
    assign w_q_final   = r_by_zero ? 32'hFFFF_FFFF : (r_neg_q ? neg32(w_quot_next) : w_quot_next);
    assign w_r_final   = r_by_zero ? r_dividend   : (r_neg_r ? neg32(w_rem_next) : w_rem_next);

    // Divider state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_state <= DIV_IDLE;
        end else begin
            r_div_state <= w_div_state_nxt;
        end
    end

    // Divider next-state
    always_comb begin
        w_div_state_nxt = r_div_state;
        case (r_div_state)
            DIV_IDLE: w_div_state_nxt = w_div_start ? DIV_RUN : DIV_IDLE;
            DIV_RUN:  w_div_state_nxt = w_div_last ? DIV_IDLE : DIV_RUN;
            default:  w_div_state_nxt = DIV_IDLE;
        endcase
    end

    // Divider datapath: capture magnitudes, then one quotient bit per edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt  <= 5'd0;
            r_quot     <= 32'd0;
            r_rem      <= 32'd0;
            r_divisor  <= 32'd0;
            r_dividend <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_by_zero  <= 1'b0;
        end else if (w_div_start) begin
            r_div_cnt  <= 5'd0;
            r_rem      <= 32'd0;
            r_quot     <= (w_signed_div && r_e.rd1[31]) ? neg32(r_e.rd1) : r_e.rd1;
            r_divisor  <= (w_signed_div && r_e.rd2[31]) ? neg32(r_e.rd2) : r_e.rd2;
            r_dividend <= r_e.rd1;
            r_neg_q    <= w_signed_div && (r_e.rd1[31] ^ r_e.rd2[31]);
            r_neg_r    <= w_signed_div && r_e.rd1[31];
            r_by_zero  <= (r_e.rd2 == 32'd0);
        end else if (w_md_busy) begin
            r_div_cnt  <= r_div_cnt + 5'd1;
            r_quot     <= w_quot_next;
            r_rem      <= w_rem_next;
        end
    end

    // HI/LO update: divide completion, multiply, or move-to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_div_last) begin
            r_hi <= w_r_final;
            r_lo <= w_q_final;
        end else begin
            case (r_e.mult_op)
                MD_MULT:  {r_hi, r_lo} <= w_prod_s;
                MD_MULTU: {r_hi, r_lo} <= w_prod_u;
                MD_MTHI:  r_hi <= r_e.rd1;
                MD_MTLO:  r_lo <= r_e.rd1;
                default:  r_hi <= r_hi;
            endcase
        end
    end

    assign RegWriteE  = r_e.reg_write;
    assign MemWriteE  = r_e.mem_write;
    assign jumpE      = r_e.jump;
    assign MemtoRegE  = r_e.mem_to_reg;
    assign WriteRegE  = r_e.write_reg;
    assign WriteDataE = r_e.rd2;
    assign PCPlus4E   = r_e.pc_plus4;
    assign StallMD    = w_stall;

endmodule

// File: tb/tb_execute.sv
// Randomized self-checking bench for the execute stage against an
// instruction-level HI/LO and ALU reference model.
module tb_execute;

    typedef struct packed {
        logic        rw, mw, j;
        logic [3:0]  m2r, aluc;
        logic        alusrc, regdst;
        logic [2:0]  mop;
        logic [1:0]  mf;
        logic [4:0]  shamt, rt, rd;
        logic [31:0] rd1, rd2, imm, pc;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush_s = 1'b0;
    ins_t cur_d = '0;

    logic        RegWriteE, MemWriteE, jumpE, StallMD;
    logic [3:0]  MemtoRegE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;

    int n_checks = 0;
    int n_errors = 0;

    ins_t        m_e;
    bit          m_e_bubble;
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    int          m_busy;

    always #5 clk = ~clk;

    execute dut (
        .clk(clk), .rst(rst), .FlushE(flush_s),
        .RegWriteD(cur_d.rw), .MemWriteD(cur_d.mw), .jumpD(cur_d.j),
        .MemtoRegD(cur_d.m2r), .ALUControlD(cur_d.aluc), .ALUSrcD(cur_d.alusrc),
        .RegDstD(cur_d.regdst), .MultOpD(cur_d.mop), .MfSelD(cur_d.mf),
        .ShamtD(cur_d.shamt), .RtD(cur_d.rt), .RdD(cur_d.rd),
        .RD1D(cur_d.rd1), .RD2D(cur_d.rd2), .SignImmD(cur_d.imm), .PCPlus4D(cur_d.pc),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .jumpE(jumpE),
        .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE), .ALUMultOutE(ALUMultOutE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .StallMD(StallMD)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ALU reference using integer arithmetic on the operand values
    function automatic logic [31:0] ref_alu(input ins_t e);
        logic [31:0] a, b;
        longint sa, sb, p;
        a  = e.rd1;
        b  = e.alusrc ? e.imm : e.rd2;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = longint'(1) << e.shamt;
        case (e.aluc)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return 32'(longint'(a) + longint'(b));
            4'd3:    return a ^ b;
            4'd4:    return ~(a | b);
            4'd6:    return 32'(longint'(a) - longint'(b));
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:    return 32'(longint'(b) * p);
            4'd9:    return 32'(longint'(b) / p);
            4'd10:   return (sb >= 0) ? 32'(sb / p) : 32'(-((-sb + p - 1) / p));
            4'd11:   return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_busy = 0;
        m_e = '0; m_e_bubble = 1'b0;
    endtask

    task automatic model_edge(input bit stall);
        logic [63:0] p;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else begin
            case (m_e.mop)
                3'd1: begin
                    p = 64'(longint'($signed(m_e.rd1)) * longint'($signed(m_e.rd2)));
                    m_hi = p[63:32]; m_lo = p[31:0];
                end
                3'd2: begin
                    p = {32'd0, m_e.rd1} * {32'd0, m_e.rd2};
                    m_hi = p[63:32]; m_lo = p[31:0];
                end
                3'd3, 3'd4: begin
                    div_ref(m_e.mop == 3'd3, m_e.rd1, m_e.rd2, m_pend_lo, m_pend_hi);
                    m_busy = 32;
                end
                3'd5:    m_hi = m_e.rd1;
                3'd6:    m_lo = m_e.rd1;
                default: m_busy = 0;
            endcase
        end
        m_e_bubble = flush_s || stall;
        m_e = m_e_bubble ? ins_t'('0) : cur_d;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_res;
        check_val("ctrl", {20'd0, RegWriteE, MemWriteE, jumpE, MemtoRegE, WriteRegE},
                  {20'd0, m_e.rw, m_e.mw, m_e.j, m_e.m2r, m_e.regdst ? m_e.rd : m_e.rt});
        if (!m_e_bubble) begin
            exp_res = (m_e.mf == 2'd1) ? m_hi : (m_e.mf == 2'd2) ? m_lo : ref_alu(m_e);
            check_val("result", ALUMultOutE, exp_res);
            check_val("wdata", WriteDataE, m_e.rd2);
            check_val("pc4", PCPlus4E, m_e.pc);
        end
    endtask

    // One clock: check stall request, advance the edge, check E outputs
    task automatic tick(output bit stalled);
        bit exp_stall;
        #2;
        exp_stall = ((cur_d.mop != 3'd0) || (cur_d.mf != 2'd0)) &&
                    ((m_busy > 0) || (m_e.mop == 3'd3) || (m_e.mop == 3'd4));
        check_val("stall", {31'd0, StallMD}, {31'd0, exp_stall});
        stalled = exp_stall;
        @(posedge clk);
        model_edge(exp_stall);
        #1;
        check_outputs();
    endtask

    task automatic issue(input ins_t d, input bit fl, output int nstall);
        bit st;
        nstall  = 0;
        cur_d   = d;
        flush_s = fl;
        st      = 1'b1;
        for (int k = 0; k < 100 && st; k++) begin
            tick(st);
            if (st) nstall++;
        end
        check_val("stall_bound", {31'd0, st}, 32'd0);
        flush_s = 1'b0;
    endtask

    function automatic ins_t mk_alu(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b, input logic src, input logic [31:0] imm);
        ins_t d = '0;
        d.rw = 1'b1; d.aluc = c; d.rd1 = a; d.rd2 = b; d.alusrc = src; d.imm = imm;
        d.shamt = 5'd4; d.rt = 5'd9; d.rd = 5'd17; d.regdst = 1'b1; d.pc = 32'h0040_0010;
        return d;
    endfunction

    function automatic ins_t mk_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ins_t d = '0;
        d.mop = op; d.rd1 = a; d.rd2 = b; d.pc = 32'h0040_0020;
        return d;
    endfunction

    function automatic ins_t mk_mf(input logic [1:0] sel);
        ins_t d = '0;
        d.rw = 1'b1; d.mf = sel; d.rd = 5'd3; d.regdst = 1'b1; d.pc = 32'h0040_0030;
        return d;
    endfunction

    function automatic logic [31:0] rand_word();
        return ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom();
    endfunction

    function automatic ins_t rand_ins();
        ins_t d;
        int   sel;
        logic [2:0] md_ops [4] = '{3'd1, 3'd2, 3'd5, 3'd6};
        d = '0;
        d.rw = 1'($urandom_range(1, 0)); d.mw = 1'($urandom_range(1, 0));
        d.j = 1'($urandom_range(1, 0)); d.m2r = 4'($urandom_range(15, 0));
        d.regdst = 1'($urandom_range(1, 0)); d.rt = 5'($urandom_range(31, 0));
        d.rd = 5'($urandom_range(31, 0)); d.pc = $urandom();
        d.rd1 = rand_word(); d.rd2 = rand_word(); d.imm = rand_word();
        sel = $urandom_range(99, 0);
        if (sel < 65) begin
            d.aluc = 4'($urandom_range(15, 0));
            d.alusrc = 1'($urandom_range(1, 0));
            d.shamt = 5'($urandom_range(31, 0));
        end else if (sel < 80) begin
            d.mop = md_ops[$urandom_range(3, 0)];
        end else if (sel < 85) begin
            d.mop = ($urandom_range(1, 0) == 0) ? 3'd3 : 3'd4;
            if ($urandom_range(7, 0) == 0) d.rd2 = 32'd0;
        end else begin
            d.mf = ($urandom_range(1, 0) == 0) ? 2'd1 : 2'd2;
        end
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sweep_exp [16] = '{32'h0000_0020, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFD0,
                                        32'h0000_000F, 32'd0, 32'hFFFF_FFD0, 32'd1,
                                        32'h0000_0200, 32'h0000_0002, 32'h0000_0002, 32'd0,
                                        32'd0, 32'd0, 32'd0, 32'd0};
        int ns, tot;
        bit st;

        // Reset with a HI/LO op sitting in D
        cur_d = mk_md(3'd3, 32'd5, 32'd1);
        model_reset();
        #12;
        check_val("rst_stall", {31'd0, StallMD}, 32'd0);
        check_val("rst_res", ALUMultOutE, 32'd0);
        check_val("rst_all", {RegWriteE, MemWriteE, jumpE, MemtoRegE, WriteRegE} | WriteDataE | PCPlus4E, 32'd0);
        rst = 1'b1;
        cur_d = '0;
        tick(st);

        // ALU sweep
        for (int c = 0; c < 16; c++) begin
            issue(mk_alu(4'(c), 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 32'd0), 1'b0, ns);
            check_val($sformatf("sweep%0d", c), ALUMultOutE, sweep_exp[c]);
        end
        issue(mk_alu(4'd10, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0), 1'b0, ns);
        check_val("sra_imm", ALUMultOutE, 32'hFFFF_FFFF);

        // Multiply and move: no stall anywhere
        tot = 0;
        issue(mk_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002), 1'b0, ns); tot += ns;
        issue(mk_mf(2'd2), 1'b0, ns); tot += ns;
        check_val("mult_lo", ALUMultOutE, 32'hFFFF_FFFE);
        issue(mk_mf(2'd1), 1'b0, ns); tot += ns;
        check_val("mult_hi", ALUMultOutE, 32'hFFFF_FFFF);
        issue(mk_md(3'd2, 32'hFFFF_FFFF, 32'h0000_0002), 1'b0, ns); tot += ns;
        issue(mk_mf(2'd1), 1'b0, ns); tot += ns;
        check_val("multu_hi", ALUMultOutE, 32'h0000_0001);
        issue(mk_md(3'd5, 32'hCAFE_0001, 32'd0), 1'b0, ns); tot += ns;
        issue(mk_mf(2'd1), 1'b0, ns); tot += ns;
        check_val("mthi", ALUMultOutE, 32'hCAFE_0001);
        check_val("mult_nostall", 32'(tot), 32'd0);

        // Signed divide then MFLO: 33-cycle stall
        issue(mk_md(3'd3, 32'hFFFF_FFF9, 32'd2), 1'b0, ns);
        issue(mk_mf(2'd2), 1'b0, ns);
        check_val("div_stall", 32'(ns), 32'd33);
        check_val("div_lo", ALUMultOutE, 32'hFFFF_FFFD);
        issue(mk_mf(2'd1), 1'b0, ns);
        check_val("div_hi", ALUMultOutE, 32'hFFFF_FFFF);

        // Divide corners
        issue(mk_md(3'd4, 32'd10, 32'd0), 1'b0, ns);
        issue(mk_mf(2'd2), 1'b0, ns);
        check_val("dz_lo", ALUMultOutE, 32'hFFFF_FFFF);
        issue(mk_mf(2'd1), 1'b0, ns);
        check_val("dz_hi", ALUMultOutE, 32'h0000_000A);
        issue(mk_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), 1'b0, ns);
        issue(mk_mf(2'd2), 1'b0, ns);
        check_val("ovf_lo", ALUMultOutE, 32'h8000_0000);
        issue(mk_mf(2'd1), 1'b0, ns);
        check_val("ovf_hi", ALUMultOutE, 32'd0);

        // Reset in the middle of a divide
        issue(mk_md(3'd4, 32'd100, 32'd3), 1'b0, ns);
        for (int k = 0; k < 10; k++) issue(mk_alu(4'd2, 32'(k), 32'd1, 1'b0, 32'd0), 1'b0, ns);
        cur_d = mk_mf(2'd2);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_val("mrst_stall", {31'd0, StallMD}, 32'd0);
        check_val("mrst_res", ALUMultOutE, 32'd0);
        check_val("mrst_ctrl", {23'd0, RegWriteE, MemWriteE, jumpE, MemtoRegE, WriteRegE} | WriteDataE | PCPlus4E, 32'd0);
        rst = 1'b1;
        issue(mk_mf(2'd2), 1'b0, ns);
        check_val("mrst_lo", ALUMultOutE, 32'd0);
        check_val("mrst_nostall", 32'(ns), 32'd0);
        issue(mk_alu(4'd2, 32'd5, 32'd7, 1'b0, 32'd0), 1'b0, ns);
        check_val("mrst_add", ALUMultOutE, 32'd12);

        // Flush a store
        cur_d = mk_alu(4'd2, 32'h100, 32'h55, 1'b1, 32'd8);
        cur_d.mw = 1'b1;
        issue(cur_d, 1'b1, ns);
        check_val("flush_mw", {31'd0, MemWriteE}, 32'd0);
        check_val("flush_rw", {31'd0, RegWriteE}, 32'd0);

        // Independent ADDs overlap a divide
        tot = 0;
        issue(mk_md(3'd4, 32'd1000, 32'd7), 1'b0, ns); tot += ns;
        for (int k = 0; k < 33; k++) begin
            issue(mk_alu(4'd2, 32'(k * 3), 32'd100, 1'b0, 32'd0), 1'b0, ns); tot += ns;
            check_val("ovl_add", ALUMultOutE, 32'(k * 3 + 100));
        end
        issue(mk_mf(2'd2), 1'b0, ns); tot += ns;
        check_val("ovl_lo", ALUMultOutE, 32'd142);
        check_val("ovl_nostall", 32'(tot), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            issue(rand_ins(), ($urandom_range(19, 0) == 0), ns);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
